move_input_conditioner: RTL

- Upstream stage of the maze block controller; it generates that block's Up/Down/Left/Right move inputs.
- Takes four raw board push-buttons, synchronises and debounces them, and emits one-hot, single-cycle move pulses.
- Priority is Right > Left > Up > Down, matching the controller's move decode.
- Held buttons auto-repeat (initial delay, then fixed period), so one press never moves the block every pixel clock.

---
 rtl/move_input_conditioner.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/move_input_conditioner.sv
// move_input_conditioner: synchronises and debounces the four board buttons
// and turns them into one-hot, single-cycle move pulses (priority R > L > U > D).
// Optional feature macro: MOVE_REPEAT_EN -- when defined, a held direction
// auto-repeats (REPEAT_DELAY to the first repeat, then every REPEAT_PERIOD);
// when undefined, each distinct press yields exactly one pulse.
module move_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned REPEAT_DELAY    = 6250000,
  parameter int unsigned REPEAT_PERIOD   = 1250000
) (
  input  logic       move_clk,
  input  logic       Reset_n,
  input  logic       BtnU,
  input  logic       BtnD,
  input  logic       BtnL,
  input  logic       BtnR,
  output logic       Up,
  output logic       Down,
  output logic       Left,
  output logic       Right,
  output logic [3:0] btn_level
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
`ifdef MOVE_REPEAT_EN
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW   = $clog2(RMAX);
`endif

  // Elaboration-time guard on parameter ranges
  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_param_chk
    $error("move_input_conditioner: all timing parameters must be >= 2");
  end

  // Bit order everywhere is {U,D,L,R}
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIRST = 2'd1
`ifdef MOVE_REPEAT_EN
    , REPEAT = 2'd2
`endif
  } state_t;

  logic [3:0]    raw;
  logic [3:0]    sync1;
  logic [3:0]    sync2;
  logic [3:0]    deb;
  logic [DW-1:0] cnt [4];
  logic [3:0]    active;
  logic [3:0]    latched;
  logic [3:0]    latched_nxt;
  logic [3:0]    pulse;
  logic [3:0]    pulse_nxt;
  state_t        state;
  state_t        state_nxt;
`ifdef MOVE_REPEAT_EN
  logic [RW-1:0] rcnt;
  logic [RW-1:0] rcnt_nxt;
`endif

  assign raw = {BtnU, BtnD, BtnL, BtnR};

  // Two-flop synchroniser for the asynchronous button inputs
  always_ff @(posedge move_clk) begin
    if (!Reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Per-button debounce: level changes only after DEBOUNCE_CYCLES stable samples
  always_ff @(posedge move_clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!Reset_n) begin
        cnt[i] <= '0;
        deb[i] <= 1'b0;
      end else if (sync2[i] == deb[i]) begin
        cnt[i] <= '0;
      end else if (cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
        deb[i] <= sync2[i];
        cnt[i] <= '0;
      end else begin
        cnt[i] <= cnt[i] + DW'(1);
      end
    end
  end

  assign btn_level = deb;

  // Highest-priority debounced direction, one-hot (R > L > U > D)
  always_comb begin
    active = '0;
    if (deb[0])      active = 4'b0001;
    else if (deb[1]) active = 4'b0010;
    else if (deb[3]) active = 4'b1000;
    else if (deb[2]) active = 4'b0100;
  end

  // FSM state register
  always_ff @(posedge move_clk) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (active != '0) state_nxt = FIRST;
      end
`ifdef MOVE_REPEAT_EN
      FIRST, REPEAT: begin
`else
      FIRST: begin
`endif
        if (active == '0)           state_nxt = IDLE;
        else if (active != latched) state_nxt = FIRST;
`ifdef MOVE_REPEAT_EN
        else if (rcnt == '0)        state_nxt = REPEAT;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM output logic: next pulse, latched direction and repeat count
  always_comb begin
    pulse_nxt   = '0;
    latched_nxt = latched;
`ifdef MOVE_REPEAT_EN
    rcnt_nxt    = rcnt;
`endif
    case (state)
      IDLE: begin
        if (active != '0) begin
          pulse_nxt   = active;
          latched_nxt = active;
`ifdef MOVE_REPEAT_EN
          rcnt_nxt    = RW'(REPEAT_DELAY - 1);
`endif
        end
      end
`ifdef MOVE_REPEAT_EN
      FIRST, REPEAT: begin
`else
      FIRST: begin
`endif
        if (active == '0) begin
          latched_nxt = '0;
        end else if (active != latched) begin
          pulse_nxt   = active;
          latched_nxt = active;
`ifdef MOVE_REPEAT_EN
          rcnt_nxt    = RW'(REPEAT_DELAY - 1);
        end else if (rcnt == '0) begin
          pulse_nxt   = latched;
          rcnt_nxt    = RW'(REPEAT_PERIOD - 1);
        end else begin
          rcnt_nxt    = rcnt - RW'(1);
`endif
        end
      end
      default: latched_nxt = '0;
    endcase
  end

  // Registered pulses and direction/repeat bookkeeping
  always_ff @(posedge move_clk) begin
    if (!Reset_n) begin
      pulse   <= '0;
      latched <= '0;
`ifdef MOVE_REPEAT_EN
      rcnt    <= '0;
`endif
    end else begin
      pulse   <= pulse_nxt;
      latched <= latched_nxt;
`ifdef MOVE_REPEAT_EN
      rcnt    <= rcnt_nxt;
`endif
    end
  end

  assign Up    = pulse[3];
  assign Down  = pulse[2];
  assign Left  = pulse[1];
  assign Right = pulse[0];

endmodule
